// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator core: opcode constants, FSM
// state encoding and a helper that flags reserved opcodes.
package acc_cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_LDI   = 4'b1011;
  localparam logic [3:0] OP_CLR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RETIRE = 2'd3
  } state_e;

  // Opcodes 0100 and 1101..1111 have no operation assigned.
  function automatic logic is_reserved_op(input logic [3:0] op);
    return (op == 4'b0100) || (op >= 4'b1101);
  endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Instruction issue / status bundle between a master and the core.
interface acc_cpu_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_opcode;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_we;
  logic [DATA_W-1:0] acc_out;
  logic              flag_carry;
  logic              flag_zero;
  logic              done;
  logic              illegal;
  logic              busy;

  modport master (
    output instr_valid, instr_opcode, instr_data, instr_addr, instr_we,
    input  instr_ready, acc_out, flag_carry, flag_zero, done, illegal, busy
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_data, instr_addr, instr_we,
    output instr_ready, acc_out, flag_carry, flag_zero, done, illegal, busy
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the new accumulator value and carry for one
// opcode and says whether the accumulator should be written at all.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              write_acc
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra top bit holds carry-out for ADD and borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; anything not listed keeps A and the carry untouched.
  always_comb begin
    result    = a;
    carry_out = carry_in;
    write_acc = 1'b0;
    case (opcode)
      OP_ADD: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        write_acc = 1'b1;
      end
      OP_SUB: begin
        result    = diff[DATA_W-1:0];
        carry_out = diff[DATA_W];
        write_acc = 1'b1;
      end
      OP_LOAD, OP_LDI: begin
        result    = b;
        write_acc = 1'b1;
      end
      OP_AND: begin
        result    = a & b;
        write_acc = 1'b1;
      end
      OP_OR: begin
        result    = a | b;
        write_acc = 1'b1;
      end
      OP_XOR: begin
        result    = a ^ b;
        write_acc = 1'b1;
      end
      OP_NOT: begin
        result    = ~a;
        write_acc = 1'b1;
      end
      OP_SHL: begin
        result    = {a[DATA_W-2:0], 1'b0};
        carry_out = a[DATA_W-1];
        write_acc = 1'b1;
      end
      OP_SHR: begin
        result    = {1'b0, a[DATA_W-1:1]};
        carry_out = a[0];
        write_acc = 1'b1;
      end
      OP_CLR: begin
        result    = '0;
        carry_out = 1'b0;
        write_acc = 1'b1;
      end
      default: begin
        result    = a;
        carry_out = carry_in;
        write_acc = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Single-accumulator core: valid/ready issue, a small clearable data memory
// with registered read, and a four-state sequencer around the ALU.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input logic       clk,
  input logic       rst,
  acc_cpu_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_reg, state_next;
  logic [3:0]        opcode_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              carry_reg;
  logic              zero_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic              accept;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_write_acc;

  assign accept = bus.instr_valid && (state_reg == ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: LOAD takes an extra cycle for the memory read.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept)
          state_next = (bus.instr_opcode == OP_LOAD) ? ST_MEM_RD : ST_EXEC;
      end
      ST_MEM_RD: state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_RETIRE;
      ST_RETIRE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Capture the instruction fields on accept; held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_reg <= OP_ADD;
      data_reg   <= '0;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
    end else if (accept) begin
      opcode_reg <= bus.instr_opcode;
      data_reg   <= bus.instr_data;
      addr_reg   <= bus.instr_addr;
      we_reg     <= bus.instr_we;
    end
  end

  // Data memory: cleared by reset, written by STORE at the EXEC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (state_reg == ST_EXEC && opcode_reg == OP_STORE && we_reg) begin
      mem_reg[addr_reg] <= acc_reg;
    end
  end

  // Registered memory read, taken while in MEM_RD.
  always_ff @(posedge clk) begin
    if (rst)                         rd_data_reg <= '0;
    else if (state_reg == ST_MEM_RD) rd_data_reg <= mem_reg[addr_reg];
  end

  // LOAD feeds the memory word through the ALU's B operand.
  assign alu_b = (opcode_reg == OP_LOAD) ? rd_data_reg : data_reg;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode    (opcode_reg),
    .a         (acc_reg),
    .b         (alu_b),
    .carry_in  (carry_reg),
    .result    (alu_result),
    .carry_out (alu_carry),
    .write_acc (alu_write_acc)
  );

  // Architectural state update at the EXEC -> RETIRE edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b1;
    end else if (state_reg == ST_EXEC) begin
      carry_reg <= alu_carry;
      if (alu_write_acc) begin
        acc_reg  <= alu_result;
        zero_reg <= (alu_result == '0);
      end
    end
  end

  assign bus.instr_ready = (state_reg == ST_IDLE);
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.done        = (state_reg == ST_RETIRE);
  assign bus.illegal     = (state_reg == ST_RETIRE) && is_reserved_op(opcode_reg);
  assign bus.acc_out     = acc_reg;
  assign bus.flag_carry  = carry_reg;
  assign bus.flag_zero   = zero_reg;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core (DATA_W=4, ADDR_W=4).
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_total = 0;

  acc_cpu_if #(.DATA_W(4), .ADDR_W(4)) bus ();

  acc_cpu_core #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] d;
    logic [3:0] a;
    logic       w;
    int         lat;
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       ill;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse counter and busy/ready consistency, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done === 1'b1) done_total++;
      total++;
      if (bus.busy !== !bus.instr_ready) begin
        bad++;
        $display("FAIL busy_vs_ready: got busy=%b ready=%b", bus.busy, bus.instr_ready);
      end
    end
  end

  // Issue one instruction from a falling edge in IDLE; returns on the falling
  // edge of the following IDLE cycle.
  task automatic issue(input vec_t v, input int idx);
    int n;
    chk($sformatf("v%0d ready_before", idx), bus.instr_ready, 1);
    bus.instr_valid  = 1'b1;
    bus.instr_opcode = v.op;
    bus.instr_data   = v.d;
    bus.instr_addr   = v.a;
    bus.instr_we     = v.w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.instr_valid = 1'b0;
    end while (bus.done !== 1'b1 && n < 10);
    chk($sformatf("v%0d latency", idx), n, v.lat);
    chk($sformatf("v%0d acc", idx), bus.acc_out, v.acc);
    chk($sformatf("v%0d carry", idx), bus.flag_carry, v.c);
    chk($sformatf("v%0d zero", idx), bus.flag_zero, v.z);
    chk($sformatf("v%0d illegal", idx), bus.illegal, v.ill);
    @(negedge clk);
    chk($sformatf("v%0d ready_after", idx), bus.instr_ready, 1);
    chk($sformatf("v%0d done_after", idx), bus.done, 0);
    $display("v%0d op=%b d=%h a=%h we=%b -> acc=%h c=%b z=%b ill=%b lat=%0d",
             idx, v.op, v.d, v.a, v.w, bus.acc_out, bus.flag_carry, bus.flag_zero, v.ill, n);
  endtask

  initial begin
    int snap;
    vec_t v;
    bus.instr_valid  = 1'b0;
    bus.instr_opcode = 4'h0;
    bus.instr_data   = 4'h0;
    bus.instr_addr   = 4'h0;
    bus.instr_we     = 1'b0;

    //            op        d     a     w  lat acc   c  z  ill
    vt.push_back('{OP_LDI,   4'h5, 4'h0, 0, 2, 4'h5, 0, 0, 0});
    vt.push_back('{OP_ADD,   4'hC, 4'h0, 0, 2, 4'h1, 1, 0, 0});
    vt.push_back('{OP_SUB,   4'h3, 4'h0, 0, 2, 4'hE, 1, 0, 0});
    vt.push_back('{OP_SUB,   4'hE, 4'h0, 0, 2, 4'h0, 0, 1, 0});
    vt.push_back('{OP_LDI,   4'h9, 4'h0, 0, 2, 4'h9, 0, 0, 0});
    vt.push_back('{OP_STORE, 4'h0, 4'h3, 0, 2, 4'h9, 0, 0, 0});
    vt.push_back('{OP_LOAD,  4'h0, 4'h3, 0, 3, 4'h0, 0, 1, 0});
    vt.push_back('{OP_LDI,   4'h9, 4'h0, 0, 2, 4'h9, 0, 0, 0});
    vt.push_back('{OP_STORE, 4'h0, 4'h3, 1, 2, 4'h9, 0, 0, 0});
    vt.push_back('{OP_LDI,   4'h0, 4'h0, 0, 2, 4'h0, 0, 1, 0});
    vt.push_back('{OP_LOAD,  4'h0, 4'h3, 0, 3, 4'h9, 0, 0, 0});
    vt.push_back('{OP_SHL,   4'h0, 4'h0, 0, 2, 4'h2, 1, 0, 0});
    vt.push_back('{OP_SHR,   4'h0, 4'h0, 0, 2, 4'h1, 0, 0, 0});
    vt.push_back('{OP_NOT,   4'h0, 4'h0, 0, 2, 4'hE, 0, 0, 0});
    vt.push_back('{OP_AND,   4'h6, 4'h0, 0, 2, 4'h6, 0, 0, 0});
    vt.push_back('{OP_OR,    4'h9, 4'h0, 0, 2, 4'hF, 0, 0, 0});
    vt.push_back('{OP_SHL,   4'h0, 4'h0, 0, 2, 4'hE, 1, 0, 0});
    vt.push_back('{OP_XOR,   4'hE, 4'h0, 0, 2, 4'h0, 1, 1, 0});
    vt.push_back('{4'b0100,  4'h3, 4'h0, 0, 2, 4'h0, 1, 1, 1});
    vt.push_back('{4'b1111,  4'h7, 4'h0, 1, 2, 4'h0, 1, 1, 1});
    vt.push_back('{OP_LDI,   4'h7, 4'h0, 0, 2, 4'h7, 1, 0, 0});
    vt.push_back('{OP_STORE, 4'h0, 4'h5, 1, 2, 4'h7, 1, 0, 0});
    vt.push_back('{OP_CLR,   4'h0, 4'h0, 0, 2, 4'h0, 0, 1, 0});
    vt.push_back('{OP_LOAD,  4'h0, 4'h5, 0, 3, 4'h7, 0, 0, 0});
    vt.push_back('{OP_CLR,   4'h0, 4'h0, 0, 2, 4'h0, 0, 1, 0});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst acc", bus.acc_out, 0);
    chk("rst carry", bus.flag_carry, 0);
    chk("rst zero", bus.flag_zero, 1);
    chk("rst done", bus.done, 0);
    chk("rst illegal", bus.illegal, 0);
    chk("rst ready", bus.instr_ready, 1);

    foreach (vt[i]) issue(vt[i], i);

    // Held valid: ADD 1 held across six rising edges from acc=0.
    snap = done_total;
    bus.instr_opcode = OP_ADD;
    bus.instr_data   = 4'h1;
    bus.instr_addr   = 4'h0;
    bus.instr_we     = 1'b0;
    bus.instr_valid  = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold done_count", done_total - snap, 2);
    chk("hold acc", bus.acc_out, 2);
    chk("hold carry", bus.flag_carry, 0);
    chk("hold ready", bus.instr_ready, 1);
    $display("hold: accepts=%0d acc=%h", done_total - snap, bus.acc_out);

    // Reset during EXEC of a STORE aborts it.
    v = '{OP_LDI, 4'hA, 4'h0, 0, 2, 4'hA, 0, 0, 0};
    issue(v, 100);
    snap = done_total;
    bus.instr_opcode = OP_STORE;
    bus.instr_data   = 4'h0;
    bus.instr_addr   = 4'h7;
    bus.instr_we     = 1'b1;
    bus.instr_valid  = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("abort in_exec busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort ready", bus.instr_ready, 1);
    chk("abort acc", bus.acc_out, 0);
    chk("abort zero", bus.flag_zero, 1);
    chk("abort done", bus.done, 0);
    repeat (3) @(negedge clk);
    chk("abort no_done", done_total - snap, 0);
    $display("abort: acc=%h z=%b", bus.acc_out, bus.flag_zero);
    v = '{OP_LOAD, 4'h0, 4'h7, 0, 3, 4'h0, 0, 1, 0};
    issue(v, 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised successor to the 4-bit accumulator mini-CPU: single-accumulator core with generic data width and memory depth.
- Valid/ready instruction issue, carry/zero flags, an illegal-opcode indication and a one-cycle completion pulse.
- Instantiated under the Tiny Tapeout top wrapper, which maps ui_in/uio_in onto the instruction port and acc_out/flags onto uo_out.

Parameters:
- DATA_W, 4: accumulator, memory word and immediate width (2..16).
- ADDR_W, 4: memory address width; depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present on instr_* inputs
- instr_ready  output  1  core can accept an instruction (high only in IDLE)
- instr_opcode  input  4  operation code
- instr_data  input  DATA_W  immediate / ALU operand B
- instr_addr  input  ADDR_W  memory address for LOAD/STORE
- instr_we  input  1  write enable; STORE writes only if high at accept
- acc_out  output  DATA_W  accumulator value
- flag_carry  output  1  carry/borrow/shifted-out bit
- flag_zero  output  1  accumulator == 0
- done  output  1  one-cycle pulse when an instruction retires
- illegal  output  1  one-cycle pulse, coincident with done, for a reserved opcode
- busy  output  1  instruction in flight (= !instr_ready)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, acc=0, carry=0, zero=1, done=0, illegal=0.
  - All memory words are cleared to 0.
  - A reset mid-instruction aborts it: no memory write, no done pulse.
- Accept: instr_valid && instr_ready at edge T.
  - Opcode, data, address and we are captured into internal registers.
  - Inputs are ignored afterwards until IDLE.
- FSM states: IDLE, MEM_RD, EXEC, RETIRE.
  - IDLE -> MEM_RD on accept of LOAD; IDLE -> EXEC on any other accept.
  - MEM_RD -> EXEC (registered read of memory[addr]).
  - EXEC -> RETIRE; acc, flags and memory are updated at this edge.
  - RETIRE -> IDLE; done=1 (and illegal if applicable) for exactly this cycle.
- Latency: done is high in cycle T+2 for all opcodes except LOAD, which is T+3. The next accept is possible at the edge ending RETIRE+1 (IDLE).
- Opcodes (A = acc, B = captured data, all arithmetic mod 2**DATA_W):
  - 0000 ADD: A+B, carry = carry-out.
  - 0001 SUB: A-B, carry = borrow (1 when A<B).
  - 0010 STORE: mem[addr]=A if we; acc and flags unchanged.
  - 0011 LOAD: A=mem[addr].
  - 0101 AND, 0110 OR, 0111 XOR: A op B.
  - 1000 NOT: ~A.
  - 1001 SHL: A<<1, carry = old MSB.
  - 1010 SHR: A>>1 (logical), carry = old LSB.
  - 1011 LDI: A=B.
  - 1100 CLR: A=0, carry=0.
  - 0100, 1101..1111: reserved; state unchanged, illegal pulses with done.
- Flags:
  - Carry changes only on ADD, SUB, SHL, SHR and CLR.
  - Zero is recomputed on every accumulator write; unchanged on STORE and reserved opcodes.
- Held handshake: if instr_valid stays high while busy, no instruction is accepted and the held instruction is taken in the next IDLE cycle. A master that holds instr_valid across retirement therefore re-issues.
- STORE followed immediately by LOAD of the same address returns the stored value (the write completes before MEM_RD).
- acc_out and the flags are registered outputs, stable outside the EXEC->RETIRE edge.

Decomposition:
- Package acc_cpu_pkg: opcode constants (OP_ADD..OP_CLR), FSM state encoding, and an is_reserved_op function.
- Sub-module acc_cpu_alu: combinational, parametrised by DATA_W. Inputs opcode/A/B/carry_in; outputs result, carry_out and a write_acc strobe.
- Memory, FSM and handshake stay in acc_cpu_core.

Test Plan:
1. DATA_W=4, ADDR_W=4: release rst, issue LDI 5 at T -> done at T+2, acc_out=5, zero=0, carry=0, ready high at T+3.
2. acc=5, ADD 0xC -> acc=0x1, carry=1. Then SUB 0x3 -> acc=0xE, carry=1. Then SUB 0xE -> acc=0, zero=1, carry=0.
3. acc=9: STORE addr 3 with we=0, then LOAD 3 -> acc=0. Repeat with LDI 9 and STORE we=1, then LDI 0, LOAD 3 -> acc=9, done at T+3.
4. acc=0x9: SHL -> acc=0x2, carry=1. Then SHR -> acc=0x1, carry=0. Then NOT -> acc=0xE. Then AND 0x6 -> acc=0x6, carry unchanged.
5. Hold instr_valid high with ADD 1 for 6 cycles starting at acc=0 -> exactly two accepts, acc=2, instr_ready never high while busy. Opcode 0100 -> illegal and done pulse together, acc unchanged.
6. STORE we=1 addr 7 with acc=0xA, assert rst during EXEC -> next cycle IDLE, acc=0, zero=1, no done pulse. A subsequent LOAD 7 returns 0.
